// File: rtl/sipo_frame_ctrl.sv
// Receive-side frame controller: shifts a framed serial stream LSB-first into
// WIDTH-bit words and hands each word to a consumer over valid/ready.
module sipo_frame_ctrl #(
  parameter int WIDTH  = 4,
  parameter int WCNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WCNT_W-1:0] frame_words,
  input  logic              sin,
  input  logic              sin_valid,
  output logic              sin_ready,
  output logic [WIDTH-1:0]  pout,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic              busy,
  output logic              done
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  sreg;
  logic [WIDTH-1:0]  sreg_shift;
  logic [BCW-1:0]    bit_cnt;
  logic [WCNT_W-1:0] words_left;
  logic              go;
  logic              last_bit;
  logic              accept;
  logic              word_load;
  logic              frame_end;

  assign go         = (state == IDLE) && start && (frame_words != '0) && !abort;
  assign last_bit   = (bit_cnt == LAST_BIT);
  // abort cancels any bit offered in the same cycle, including a word's final bit
  assign accept     = sin_valid && sin_ready && !abort;
  assign word_load  = accept && last_bit;
  assign frame_end  = word_load && (words_left == WCNT_W'(1));
  assign sreg_shift = {sin, sreg[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = SHIFT;
      SHIFT:   if (abort || frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SHIFT);
    sin_ready = (state == SHIFT) && (!last_bit || !pout_valid || pout_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      pout       <= '0;
      pout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= frame_end;

      if (go) begin
        sreg       <= '0;
        bit_cnt    <= '0;
        words_left <= frame_words;
      end else if ((state == SHIFT) && abort) begin
        sreg       <= '0;
        bit_cnt    <= '0;
        words_left <= '0;
      end else if (accept) begin
        sreg <= sreg_shift;
        if (last_bit) begin
          bit_cnt <= '0;
          if (words_left != '0) words_left <= words_left - WCNT_W'(1);
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end

      // a word loading in the same cycle the old one is consumed keeps valid high
      if (word_load) begin
        pout       <= sreg_shift;
        pout_valid <= 1'b1;
      end else if (pout_ready) begin
        pout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed scenarios plus randomized
// frames, compared every cycle against a bit-counting behavioural model.
module tb_sipo_frame_ctrl;

  localparam int WIDTH  = 4;
  localparam int WCNT_W = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [WCNT_W-1:0] frame_words;
  logic              sin;
  logic              sin_valid;
  logic              sin_ready;
  logic [WIDTH-1:0]  pout;
  logic              pout_valid;
  logic              pout_ready;
  logic              busy;
  logic              done;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .WCNT_W(WCNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .frame_words (frame_words),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sin_ready   (sin_ready),
    .pout        (pout),
    .pout_valid  (pout_valid),
    .pout_ready  (pout_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is "words still owed"; a word is an integer
  // built by adding each accepted bit at weight 2**(bits seen so far).
  bit m_active;
  int m_nbits;
  int m_word;
  int m_left;
  int m_pout;
  bit m_pv;
  bit m_done;
  bit m_rdy;
  bit m_load;

  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_nbits = 0; m_word = 0; m_left = 0;
      m_pout = 0; m_pv = 0; m_done = 0;
    end else begin
      m_rdy  = m_active && (m_nbits < WIDTH - 1 || !m_pv || pout_ready);
      m_load = 0;
      m_done = 0;
      if (!m_active) begin
        if (start && frame_words != 0 && !abort) begin
          m_active = 1; m_nbits = 0; m_word = 0; m_left = int'(frame_words);
        end
      end else if (abort) begin
        m_active = 0; m_nbits = 0; m_word = 0; m_left = 0;
      end else if (sin_valid && m_rdy) begin
        m_word = m_word + (int'(sin) << m_nbits);
        m_nbits++;
        if (m_nbits == WIDTH) begin
          m_load = 1;
          m_pout = m_word;
          m_word = 0;
          m_nbits = 0;
          if (m_left > 0) m_left--;
          if (m_left == 0) begin
            m_done = 1;
            m_active = 0;
          end
        end
      end
      if (m_load) m_pv = 1;
      else if (pout_ready) m_pv = 0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_pout", 32'(pout), 32'(0));
      check("rst_pout_valid", 32'(pout_valid), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_sin_ready", 32'(sin_ready), 32'(0));
    end else begin
      check("busy", 32'(busy), 32'(m_active));
      check("sin_ready", 32'(sin_ready),
            32'(m_active && (m_nbits < WIDTH - 1 || !m_pv || pout_ready)));
      check("pout_valid", 32'(pout_valid), 32'(m_pv));
      check("pout", 32'(pout), 32'(m_pout));
      check("done", 32'(done), 32'(m_done));
      if (pout_valid && pout_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          check("delivered_word", 32'(pout), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input int fw);
    start       = 1'b1;
    frame_words = WCNT_W'(fw);
    sin_valid   = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Offer one bit and hold it until the DUT accepts it.
  task automatic send_bit(input logic b, input bit gaps, input bit rnd_pr);
    bit acc = 0;
    int guard = 0;
    while (!acc && guard < 200) begin
      sin       = b;
      sin_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_pr) pout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = sin_valid && sin_ready;
      tick();
      guard++;
    end
    check("bit_accepted", 32'(acc), 32'(1));
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps, input bit rnd_pr);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], gaps, rnd_pr);
    exp_q.push_back(w);
  endtask

  task automatic drain();
    pout_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; frame_words = '0;
    sin = 1'b0; sin_valid = 1'b0; pout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // Single word, LSB-first: bits 1,0,1,1 -> 4'hD
    pout_ready = 1'b1;
    begin_frame(1);
    send_word(4'hD, 0, 0);
    @(negedge clk);
    check("single_pout", 32'(pout), 32'hD);
    check("single_valid", 32'(pout_valid), 32'(1));
    check("single_done", 32'(done), 32'(1));
    check("single_busy", 32'(busy), 32'(0));
    tick();
    @(negedge clk);
    check("single_done_pulse", 32'(done), 32'(0));
    check("single_valid_gone", 32'(pout_valid), 32'(0));
    tick();

    // Back-pressure: word 1 = 4'h6 pending, word 2 = 4'h3 stalls on its last bit
    pout_ready = 1'b0;
    begin_frame(2);
    send_word(4'h6, 0, 0);
    send_bit(1'b1, 0, 0);
    send_bit(1'b1, 0, 0);
    send_bit(1'b0, 0, 0);
    sin = 1'b0;
    sin_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_low", 32'(sin_ready), 32'(0));
    check("bp_word1_held", 32'(pout), 32'h6);
    tick();
    @(negedge clk);
    check("bp_ready_still_low", 32'(sin_ready), 32'(0));
    tick();
    pout_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_released", 32'(sin_ready), 32'(1));
    tick();
    pout_ready = 1'b0;
    sin_valid  = 1'b0;
    exp_q.push_back(4'h3);
    @(negedge clk);
    check("bp_word2", 32'(pout), 32'h3);
    check("bp_word2_valid", 32'(pout_valid), 32'(1));
    check("bp_done", 32'(done), 32'(1));
    tick();
    drain();

    // Source gaps and random consumer over a three-word frame
    begin_frame(3);
    for (int i = 0; i < 3; i++) send_word(WIDTH'($urandom), 1, 1);
    drain();

    // Abort after 2 bits of word 2 while word 1 (4'h9) is pending
    pout_ready = 1'b0;
    begin_frame(3);
    send_word(4'h9, 0, 0);
    send_bit(1'b1, 0, 0);
    send_bit(1'b0, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_no_done", 32'(done), 32'(0));
    check("abort_pending_valid", 32'(pout_valid), 32'(1));
    check("abort_pending_word", 32'(pout), 32'h9);
    tick();
    pout_ready = 1'b1;
    tick();
    begin_frame(1);
    send_word(4'h8, 0, 0);
    @(negedge clk);
    check("after_abort_word", 32'(pout), 32'h8);
    tick();
    drain();

    // Corner starts
    begin_frame(0);
    @(negedge clk);
    check("start_zero_idle", 32'(busy), 32'(0));
    tick();
    start = 1'b1; frame_words = 4'd2; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 32'(busy), 32'(0));
    tick();
    begin_frame(1);
    send_bit(1'b1, 0, 0);
    start = 1'b1;
    frame_words = 4'd3;
    send_bit(1'b0, 0, 0);
    start = 1'b0;
    send_bit(1'b1, 0, 0);
    send_bit(1'b1, 0, 0);
    exp_q.push_back(4'hD);
    @(negedge clk);
    check("start_in_shift_done", 32'(done), 32'(1));
    check("start_in_shift_word", 32'(pout), 32'hD);
    tick();
    drain();

    // Reset mid-frame with a pending word
    pout_ready = 1'b0;
    begin_frame(2);
    send_word(4'hA, 0, 0);
    send_bit(1'b1, 0, 0);
    send_bit(1'b1, 0, 0);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_pout", 32'(pout), 32'(0));
    check("async_rst_valid", 32'(pout_valid), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_ready", 32'(sin_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
      sin = 1'($urandom_range(0, 1)); sin_valid = 1'($urandom_range(0, 1));
      pout_ready = 1'($urandom_range(0, 1)); frame_words = WCNT_W'($urandom);
    end
    tick();
    start = 1'b0; abort = 1'b0; sin_valid = 1'b0; pout_ready = 1'b1;
    #1 rst = 1'b1;
    tick();
    begin_frame(2);
    send_word(WIDTH'($urandom), 0, 0);
    send_word(WIDTH'($urandom), 0, 0);
    drain();

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int fw;
      fw = $urandom_range(1, 3);
      begin_frame(fw);
      for (int w = 0; w < fw; w++) send_word(WIDTH'($urandom), 1, 1);
    end
    drain();
    check("all_words_delivered", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
